// File: rtl/mul3_rebuild.sv
// Rebuilds n = 3*q + r by repeated addition of 3, one addition per clock.
// Out-of-range results saturate to the maximum and raise err instead of wrapping.
module mul3_rebuild #(
  parameter int QW = 3,
  parameter int W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] q,
  input  logic [1:0]    r,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  o,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Accumulator carries two extra bits so acc + 3 never wraps before the range check.
  localparam logic [W+1:0] ACC_MAX = {2'b00, {W{1'b1}}};
  localparam logic [W-1:0] O_MAX   = {W{1'b1}};
  localparam logic [W+1:0] THREE   = (W + 2)'(3);

  state_t        state_reg, state_next;
  logic [W+1:0]  acc_reg, acc_next;
  logic [QW-1:0] cnt_reg, cnt_next;
  logic          ovf_reg, ovf_next;
  logic [W-1:0]  o_reg, o_next;
  logic          err_reg, err_next;

  logic [W+1:0]  acc_sum;
  logic [W+1:0]  r_ext;

  assign acc_sum = acc_reg + THREE;
  assign r_ext   = {{W{1'b0}}, r};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      o_reg     <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      o_reg     <= o_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    o_next     = o_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (r == 2'd3) begin
            state_next = DONE;
            o_next     = '0;
            err_next   = 1'b1;
          end else begin
            state_next = ADD;
            acc_next   = r_ext;
            cnt_next   = q;
            ovf_next   = (r_ext > ACC_MAX);
          end
        end
      end
      ADD: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - QW'(1);
          // Once overflow is seen the accumulator freezes; cnt keeps running for fixed latency.
          if (ovf_reg || (acc_sum > ACC_MAX)) begin
            ovf_next = 1'b1;
          end else begin
            acc_next = acc_sum;
          end
        end else begin
          state_next = DONE;
          o_next     = ovf_reg ? O_MAX : acc_reg[W-1:0];
          err_next   = ovf_reg;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == ADD);
  assign done = (state_reg == DONE);
  assign o    = o_reg;
  assign err  = err_reg;

endmodule
